minitb_ahb_slave_mem: RTL and testbench

- Synthesizable AHB-lite single-slave memory model that sits directly downstream of the team's AHB master bus-functional model.
- Consumes htrans/haddr/hwrite/hwdata and produces hready/hrdata.
- Wait states are programmable per transfer, so master pipelining and wait handling can be exercised end to end.
- haddr is a word index; there is no hsize and no hresp.

---
 rtl/minitb_ahb_slave_mem.sv | 100 ++++++++++
 tb/tb_minitb_ahb_slave_mem.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-lite single-slave word memory with per-transfer programmable wait states.
// haddr is a word index; one transfer is in its data phase at a time and the next address overlaps its last cycle.
module minitb_ahb_slave_mem #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  input  logic [3:0]           wait_cycles,
  output logic                 hready,
  output logic [dataWidth-1:0] hrdata
);

  localparam int Depth = 1 << addrWidth;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  state_t               state_reg;
  logic [3:0]           cnt_reg;
  logic [addrWidth-1:0] addr_dp_reg;
  logic                 write_dp_reg;

  logic [dataWidth-1:0] mem [0:Depth-1];

  logic                 accept;
  logic                 commit;
  logic                 rd_on_accept;
  logic                 rd_on_wait_end;
  logic                 forward;
  logic [addrWidth-1:0] rd_addr;

  always_comb begin
    accept         = hready && htrans[1];
    commit         = (state_reg == ST_LAST) && write_dp_reg;
    rd_on_accept   = accept && !hwrite && (wait_cycles == 4'd0);
    rd_on_wait_end = (state_reg == ST_WAIT) && (cnt_reg <= 4'd1) && !write_dp_reg;
    // A zero-wait read landing on the edge that commits a write to the same word must see the new data.
    forward        = rd_on_accept && commit && (haddr == addr_dp_reg);
    rd_addr        = rd_on_accept ? haddr : addr_dp_reg;
  end

  always_ff @(posedge hclk) begin
    if (commit) begin
      mem[addr_dp_reg] <= hwdata;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      addr_dp_reg  <= '0;
      write_dp_reg <= 1'b0;
      hready       <= 1'b1;
      hrdata       <= '0;
    end else begin
      // hready is high only in IDLE and LAST, so an accept can never happen mid-wait.
      if (accept) begin
        addr_dp_reg  <= haddr;
        write_dp_reg <= hwrite;
        cnt_reg      <= wait_cycles;
        hready       <= (wait_cycles == 4'd0);
        state_reg    <= (wait_cycles == 4'd0) ? ST_LAST : ST_WAIT;
      end else begin
        case (state_reg)
          ST_WAIT: begin
            if (cnt_reg <= 4'd1) begin
              cnt_reg   <= 4'd0;
              hready    <= 1'b1;
              state_reg <= ST_LAST;
            end else begin
              cnt_reg <= cnt_reg - 4'd1;
            end
          end
          ST_LAST: begin
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end

      if (forward) begin
        hrdata <= hwdata;
      end else if (rd_on_accept || rd_on_wait_end) begin
        hrdata <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Randomized pipelined AHB master driving the memory slave, checked against an in-order transaction model.
module tb_minitb_ahb_slave_mem;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic [1:0]    htrans = 2'b00;
  logic [AW-1:0] haddr = '0;
  logic          hwrite = 1'b0;
  logic [DW-1:0] hwdata = '0;
  logic [3:0]    wait_cycles = 4'd0;
  logic          hready;
  logic [DW-1:0] hrdata;

  always #5 hclk = ~hclk;

  minitb_ahb_slave_mem #(.addrWidth(AW), .dataWidth(DW)) dut (
    .hclk(hclk),
    .hresetn(hresetn),
    .htrans(htrans),
    .haddr(haddr),
    .hwrite(hwrite),
    .hwdata(hwdata),
    .wait_cycles(wait_cycles),
    .hready(hready),
    .hrdata(hrdata)
  );

  typedef struct {
    int            idle;
    logic [AW-1:0] addr;
    bit            wr;
    logic [DW-1:0] data;
    logic [3:0]    n;
  } xfer_t;

  xfer_t         q[$];
  int            acc_cyc[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rd = '0;
  logic          rdy = 1'b1;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            txn_no = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input int idle, input int addr, input bit wr, input logic [DW-1:0] data, input int n);
    xfer_t x;
    x.idle = idle;
    x.addr = AW'(addr);
    x.wr   = wr;
    x.data = data;
    x.n    = 4'(n);
    q.push_back(x);
  endtask

  // Called #1 after a posedge with rdy holding the current hready.
  task automatic run_queue();
    int            idx = 0;
    int            idle_left;
    int            dp_waits = 0;
    int            cycles = 0;
    bit            dp_valid = 0;
    bit            acc;
    bit            fin;
    xfer_t         dp;
    logic [DW-1:0] dp_exp = '0;
    acc_cyc.delete();
    idle_left = (q.size() > 0) ? q[0].idle : 0;
    while (idx < q.size() || dp_valid) begin
      if (idx < q.size() && idle_left == 0) begin
        htrans      = $urandom_range(1) ? 2'b11 : 2'b10;
        haddr       = q[idx].addr;
        hwrite      = q[idx].wr;
        wait_cycles = rdy ? q[idx].n : 4'($urandom);
      end else begin
        htrans      = 2'($urandom_range(1));
        haddr       = AW'($urandom);
        hwrite      = 1'($urandom);
        wait_cycles = 4'($urandom);
      end
      hwdata = (dp_valid && dp.wr) ? dp.data : DW'($urandom);

      @(posedge hclk);
      acc = rdy && htrans[1];
      fin = rdy && dp_valid;
      if (fin) begin
        chk($sformatf("waits_txn%0d", txn_no), 32'(dp_waits), 32'(dp.n));
        $display("[TB] txn %0d %s addr=0x%02h data=0x%08h waits=%0d", txn_no,
                 dp.wr ? "WR" : "RD", dp.addr, dp.wr ? dp.data : dp_exp, dp_waits);
        txn_no++;
        if (!dp.wr) last_rd = dp_exp;
        dp_valid = 0;
      end
      if (!acc && idle_left > 0) idle_left--;
      if (acc) begin
        dp = q[idx];
        if (dp.wr) ref_mem[dp.addr] = dp.data;
        else       dp_exp = ref_mem[dp.addr];
        dp_valid = 1;
        dp_waits = 0;
        acc_cyc.push_back(cycles);
        idx++;
        if (idx < q.size()) idle_left = q[idx].idle;
      end

      #1;
      rdy = hready;
      if (!dp_valid) chk("idle_hready", 32'(rdy), 32'd1);
      else if (!rdy) dp_waits++;
      if (dp_valid && !dp.wr && rdy) chk($sformatf("rdata_txn%0d", txn_no), hrdata, dp_exp);
      else chk("rdata_hold", hrdata, last_rd);
      if (dp_waits > 16) begin
        chk("wait_overrun", 32'(dp_waits), 32'(dp.n));
        break;
      end
      cycles++;
      if (cycles > 20000) begin
        chk("cycle_budget", 32'd0, 32'd1);
        break;
      end
    end
    htrans = 2'b00;
    q.delete();
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    #1;
    chk("reset_hready", 32'(hready), 32'd1);
    chk("reset_hrdata", hrdata, '0);
    hresetn = 1'b1;
    rdy = hready;

    for (int a = 0; a < (1 << AW); a++)
      push(0, a, 1'b1, (a == 'h20) ? 32'h1234_5678 : DW'($urandom), 0);
    run_queue();

    // Write to 0x10 with 5 waits, then reset while it is still waiting.
    htrans = 2'b10; haddr = 8'h10; hwrite = 1'b1; wait_cycles = 4'd5; hwdata = 32'hBAD0_BAD0;
    @(posedge hclk);
    #1;
    htrans = 2'b00;
    chk("abort_wait_hready", 32'(hready), 32'd0);
    @(posedge hclk);
    #1;
    hresetn = 1'b0;
    #1;
    chk("async_rst_hready", 32'(hready), 32'd1);
    chk("async_rst_hrdata", hrdata, '0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    last_rd = '0;
    rdy = hready;
    chk("rst_release_hready", 32'(rdy), 32'd1);
    push(0, 'h10, 1'b0, '0, 0);
    run_queue();

    push(0, 'h10, 1'b1, 32'hDEAD_BEEF, 0);
    push(0, 'h10, 1'b0, '0, 0);
    push(1, 'h20, 1'b0, '0, 3);
    run_queue();

    for (int i = 1; i <= 4; i++) push(0, i, 1'b1, 32'(32'hA0 + i), 0);
    run_queue();
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_accept_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd1);
    for (int i = 1; i <= 4; i++) push(0, i, 1'b0, '0, 0);
    run_queue();

    push(0, 'h30, 1'b1, 32'h55, 0);
    push(0, 'h30, 1'b0, '0, 0);
    run_queue();

    for (int i = 0; i < 8; i++) push(1 + (i % 3), 'h40 + (i % 3), i[0], DW'($urandom), (i % 2) * 2);
    run_queue();

    for (int i = 0; i < 300; i++)
      push(($urandom_range(3) == 0) ? int'($urandom_range(2)) : 0,
           $urandom_range(1) ? int'($urandom_range(15)) : int'($urandom_range(255)),
           1'($urandom_range(1)), DW'($urandom),
           ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(2)));
    run_queue();

    for (int a = 0; a < (1 << AW); a++) push(0, a, 1'b0, '0, 0);
    run_queue();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
